// File: rtl/mutual_pkg.sv
// Shared definitions for the mutual_rr mutual-exclusion engine.
//   proc_st_t  : per-process protocol state (I/T/C/E), 2 bits, fixed encoding
//   idx_w()    : index width for an n-entry process set, never below 1 bit
//   TOKEN_*    : polarity of the x output (1 = token free)
package mutual_pkg;

  typedef enum logic [1:0] {
    ST_I = 2'b00,
    ST_T = 2'b01,
    ST_C = 2'b10,
    ST_E = 2'b11
  } proc_st_t;

  localparam logic TOKEN_FREE = 1'b1;
  localparam logic TOKEN_HELD = 1'b0;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req   : one bit per process, set while the process is in T
//   ptr   : search start index (0..NPROC-1)
//   found : at least one request present
//   idx   : first requesting index at or after ptr, wrapping modulo NPROC
// The pointer itself is owned and registered by the parent.
module rr_arbiter #(
  parameter int NPROC = 4,
  parameter int IDXW  = 2
) (
  input  logic [NPROC-1:0] req,
  input  logic [IDXW-1:0]  ptr,
  output logic             found,
  output logic [IDXW-1:0]  idx
);

  // One extra bit so ptr+k never overflows before the modulo fold.
  logic [IDXW:0]   sum;
  logic [IDXW-1:0] pos;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    pos   = '0;
    for (int k = 0; k < NPROC; k++) begin
      sum = {1'b0, ptr} + (IDXW+1)'(k);
      if (sum >= (IDXW+1)'(NPROC)) sum = sum - (IDXW+1)'(NPROC);
      pos = sum[IDXW-1:0];
      if (!found && req[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/mutual_rr.sv
// N-process mutual-exclusion engine. Each process cycles I -> T -> C -> E -> I
// and contends for one shared token; grants are round-robin so nobody starves
// while holders keep releasing, and an optional crit timeout forces holders out.
//   clk, reset   : clock, synchronous active-high reset
//   try_req      : per-process request to leave I
//   exit_req     : per-process request to leave C
//   state        : packed states, process i at [2i+1:2i] (I=00 T=01 C=10 E=11)
//   x            : 1 while the token is free
//   grant_valid  : one-cycle pulse on each T->C grant
//   grant_idx    : index of the most recent grant
//   mutex_err    : sticky safety violation flag (two in C, or C with x=1)
//   starve       : per-process sticky flag, set after STARVE_LIMIT T cycles
module mutual_rr
  import mutual_pkg::*;
#(
  parameter int NPROC        = 4,
  parameter int CRIT_MAX     = 8,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NPROC-1:0]            try_req,
  input  logic [NPROC-1:0]            exit_req,
  output logic [2*NPROC-1:0]          state,
  output logic                        x,
  output logic                        grant_valid,
  output logic [idx_w(NPROC)-1:0]     grant_idx,
  output logic                        mutex_err,
  output logic [NPROC-1:0]            starve
);

  localparam int IDXW = idx_w(NPROC);
  // Timer only has to reach CRIT_MAX-1.
  localparam int TW   = (CRIT_MAX < 2) ? 1 : $clog2(CRIT_MAX);
  localparam int WW   = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [NPROC-1:0] in_t, in_c, in_e;
  logic [IDXW-1:0]  rr_ptr;
  logic [TW-1:0]    crit_tmr;
  logic             arb_found;
  logic [IDXW-1:0]  arb_idx;
  logic             grant, forced, any_c, any_e, multi_c;

  rr_arbiter #(.NPROC(NPROC), .IDXW(IDXW)) u_arb (
    .req   (in_t),
    .ptr   (rr_ptr),
    .found (arb_found),
    .idx   (arb_idx)
  );

  assign grant   = (x == TOKEN_FREE) && arb_found;
  assign any_c   = |in_c;
  assign any_e   = |in_e;
  // More than one bit set: clearing the lowest set bit leaves something.
  assign multi_c = |(in_c & (in_c - 1'b1));
  assign forced  = (CRIT_MAX != 0) && (crit_tmr == TW'(CRIT_MAX - 1));

  // Token, pointer, timer and grant reporting. Grant needs x free while an
  // E release needs x held, so the two token updates never collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      x           <= TOKEN_FREE;
      rr_ptr      <= '0;
      crit_tmr    <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      mutex_err   <= 1'b0;
    end else begin
      grant_valid <= grant;
      if (grant) begin
        x         <= TOKEN_HELD;
        grant_idx <= arb_idx;
        rr_ptr    <= (arb_idx == IDXW'(NPROC - 1)) ? '0 : arb_idx + 1'b1;
        crit_tmr  <= '0;
      end else begin
        if (any_e) x <= TOKEN_FREE;
        if (any_c) crit_tmr <= crit_tmr + 1'b1;
      end
      mutex_err <= mutex_err | multi_c | ((x == TOKEN_FREE) && any_c);
    end
  end

  for (genvar i = 0; i < NPROC; i++) begin : g_proc
    proc_st_t       st_r;
    logic [WW-1:0]  wcnt;
    logic           starve_r;
    logic           win;

    assign win = grant && (arb_idx == IDXW'(i));

    always_ff @(posedge clk) begin
      if (reset) begin
        st_r     <= ST_I;
        wcnt     <= '0;
        starve_r <= 1'b0;
      end else begin
        case (st_r)
          ST_I: if (try_req[i]) st_r <= ST_T;
          ST_T: if (win) st_r <= ST_C;
          ST_C: if (exit_req[i] || forced) st_r <= ST_E;
          ST_E: st_r <= ST_I;
          default: st_r <= ST_I;
        endcase
        // Count cycles spent waiting in T; the grant cycle itself leaves T.
        if (st_r == ST_T && !win) begin
          if (wcnt != WW'(STARVE_LIMIT)) wcnt <= wcnt + 1'b1;
          if (wcnt == WW'(STARVE_LIMIT - 1)) starve_r <= 1'b1;
        end else begin
          wcnt <= '0;
        end
      end
    end

    assign state[2*i +: 2] = st_r;
    assign in_t[i]         = (st_r == ST_T);
    assign in_c[i]         = (st_r == ST_C);
    assign in_e[i]         = (st_r == ST_E);
    assign starve[i]       = starve_r;
  end

endmodule

// File: tb/tb_mutual_rr.sv
module tb_mutual_rr;

  localparam int NA = 4, CA = 3, SA = 5;   // unit 0
  localparam int NB = 5, CB = 0, SB = 5;   // unit 1: non-power-of-two, no timeout

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] tr = '0, er = '0;

  logic [2*NA-1:0] st_a; logic x_a, gv_a, me_a; logic [1:0] gi_a; logic [NA-1:0] sv_a;
  logic [2*NB-1:0] st_b; logic x_b, gv_b, me_b; logic [2:0] gi_b; logic [NB-1:0] sv_b;

  mutual_rr #(.NPROC(NA), .CRIT_MAX(CA), .STARVE_LIMIT(SA)) dut_a (
    .clk(clk), .reset(reset), .try_req(tr[NA-1:0]), .exit_req(er[NA-1:0]),
    .state(st_a), .x(x_a), .grant_valid(gv_a), .grant_idx(gi_a),
    .mutex_err(me_a), .starve(sv_a));

  mutual_rr #(.NPROC(NB), .CRIT_MAX(CB), .STARVE_LIMIT(SB)) dut_b (
    .clk(clk), .reset(reset), .try_req(tr[NB-1:0]), .exit_req(er[NB-1:0]),
    .state(st_b), .x(x_b), .grant_valid(gv_b), .grant_idx(gi_b),
    .mutex_err(me_b), .starve(sv_b));

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // States as spec integers: 0=I 1=T 2=C 3=E.
  int  np_[2] = '{NA, NB};
  int  cm_[2] = '{CA, CB};
  int  sl_[2] = '{SA, SB};
  int  m_st[2][16];
  int  m_wait[2][16];
  bit  m_starve[2][16];
  bit  m_x[2];
  int  m_ptr[2];
  int  m_age[2];       // cycles the current holder has already spent in C
  bit  m_gv[2];
  int  m_gidx[2];
  bit  m_valid = 1'b0;

  task automatic model_step(input int u, input bit rst, input logic [4:0] t, input logic [4:0] e);
    int nst[16];
    bit grant, forced, anye, anyc;
    int win, p;
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        m_st[u][i] = 0; m_wait[u][i] = 0; m_starve[u][i] = 1'b0;
      end
      m_x[u] = 1'b1; m_ptr[u] = 0; m_age[u] = 0; m_gv[u] = 1'b0; m_gidx[u] = 0;
      return;
    end
    grant = 1'b0; win = 0; anye = 1'b0; anyc = 1'b0;
    if (m_x[u]) begin
      for (int k = 0; k < np_[u]; k++) begin
        p = (m_ptr[u] + k) % np_[u];
        if (!grant && m_st[u][p] == 1) begin grant = 1'b1; win = p; end
      end
    end
    forced = (cm_[u] != 0) && (m_age[u] == cm_[u] - 1);
    for (int i = 0; i < np_[u]; i++) begin
      nst[i] = m_st[u][i];
      case (m_st[u][i])
        0: if (t[i]) nst[i] = 1;
        1: if (grant && win == i) nst[i] = 2;
        2: begin anyc = 1'b1; if (e[i] || forced) nst[i] = 3; end
        default: begin anye = 1'b1; nst[i] = 0; end
      endcase
    end
    for (int i = 0; i < np_[u]; i++) begin
      if (m_st[u][i] == 1 && nst[i] == 1) begin
        m_wait[u][i] = (m_wait[u][i] + 1 > sl_[u]) ? sl_[u] : m_wait[u][i] + 1;
        if (m_wait[u][i] == sl_[u]) m_starve[u][i] = 1'b1;
      end else begin
        m_wait[u][i] = 0;
      end
      m_st[u][i] = nst[i];
    end
    if (grant) begin
      m_x[u] = 1'b0; m_age[u] = 0; m_ptr[u] = (win + 1) % np_[u]; m_gidx[u] = win;
    end else begin
      if (anye) m_x[u] = 1'b1;
      if (anyc) m_age[u]++;
    end
    m_gv[u] = grant;
  endtask

  always @(posedge clk) begin
    if (reset) m_valid = 1'b1;
    model_step(0, reset, tr, er);
    model_step(1, reset, tr, er);
  end

  task automatic cmp_unit(input int u, input logic [31:0] st, input logic x, input logic gv,
                          input logic [31:0] gi, input logic me, input logic [15:0] sv);
    logic [15:0] esv;
    esv = '0;
    for (int i = 0; i < np_[u]; i++) begin
      chk($sformatf("mdl_u%0d_state%0d", u, i), 32'(st[2*i +: 2]), 32'(m_st[u][i]));
      esv[i] = m_starve[u][i];
    end
    chk($sformatf("mdl_u%0d_x", u), 32'(x), 32'(m_x[u]));
    chk($sformatf("mdl_u%0d_grant_valid", u), 32'(gv), 32'(m_gv[u]));
    if (m_gv[u]) chk($sformatf("mdl_u%0d_grant_idx", u), gi, 32'(m_gidx[u]));
    chk($sformatf("mdl_u%0d_mutex_err", u), 32'(me), 32'd0);
    chk($sformatf("mdl_u%0d_starve", u), 32'(sv), 32'(esv));
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      cmp_unit(0, 32'(st_a), x_a, gv_a, 32'(gi_a), me_a, 16'(sv_a));
      cmp_unit(1, 32'(st_b), x_b, gv_b, 32'(gi_b), me_b, 16'(sv_b));
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; tr = '0; er = '0;
    cyc(); cyc();
    reset = 1'b0;
  endtask

  int exp_rr[5] = '{0, 1, 2, 3, 0};
  int rr_q[$];

  initial begin
    // reset then idle
    do_reset();
    chk("rst_grant_idx", 32'(gi_a), 32'd0);
    chk("rst_starve", 32'(sv_a), 32'd0);
    for (int c = 0; c < 20; c++) begin
      cyc();
      chk("idle_state", 32'(st_a), 32'd0);
      chk("idle_x", 32'(x_a), 32'd1);
      chk("idle_gv", 32'(gv_a), 32'd0);
      chk("idle_merr", 32'(me_a), 32'd0);
    end

    // single process full cycle
    do_reset();
    tr = 5'b00001; cyc(); tr = '0;
    chk("single_t1_T", 32'(st_a[1:0]), 32'd1);
    cyc();
    chk("single_t2_C", 32'(st_a[1:0]), 32'd2);
    chk("single_t2_x", 32'(x_a), 32'd0);
    chk("single_t2_gv", 32'(gv_a), 32'd1);
    chk("single_t2_gidx", 32'(gi_a), 32'd0);
    cyc();
    chk("single_t3_C", 32'(st_a[1:0]), 32'd2);
    chk("single_t3_gv", 32'(gv_a), 32'd0);
    er = 5'b00001; cyc(); er = '0;
    chk("single_t4_E", 32'(st_a[1:0]), 32'd3);
    chk("single_t4_x", 32'(x_a), 32'd0);
    cyc();
    chk("single_t5_I", 32'(st_a[1:0]), 32'd0);
    chk("single_t5_x", 32'(x_a), 32'd1);

    // round-robin fairness
    do_reset();
    tr = 5'b01111; er = 5'b11111;
    rr_q.delete();
    for (int c = 0; c < 60 && rr_q.size() < 5; c++) begin
      cyc();
      if (gv_a) rr_q.push_back(int'(gi_a));
    end
    tr = '0; er = '0;
    if (rr_q.size() < 5) chk("rr_grant_count", 32'(rr_q.size()), 32'd5);
    else for (int k = 0; k < 5; k++) chk($sformatf("rr_order%0d", k), 32'(rr_q[k]), 32'(exp_rr[k]));

    // forced exit, CRIT_MAX=3
    do_reset();
    tr = 5'b00100; cyc(); tr = '0;
    cyc();
    chk("force_C_entry", 32'(st_a[5:4]), 32'd2);
    chk("force_gidx", 32'(gi_a), 32'd2);
    cyc(); cyc();
    chk("force_C_last", 32'(st_a[5:4]), 32'd2);
    cyc();
    chk("force_E", 32'(st_a[5:4]), 32'd3);

    // starvation on unit 1 (no timeout)
    do_reset();
    tr = 5'b00001; cyc(); cyc();
    chk("starve_P0_C", 32'(st_b[1:0]), 32'd2);
    tr = 5'b00010; cyc(); tr = '0;
    chk("starve_P1_T", 32'(st_b[3:2]), 32'd1);
    cyc(); cyc(); cyc(); cyc();
    chk("starve_before", 32'(sv_b[1]), 32'd0);
    cyc();
    chk("starve_set", 32'(sv_b[1]), 32'd1);
    repeat (4) cyc();
    chk("starve_sticky", 32'(sv_b[1]), 32'd1);
    chk("starve_others", 32'({sv_b[4:2], sv_b[0]}), 32'd0);

    // reset mid-crit
    do_reset();
    tr = 5'b00010; cyc(); tr = '0;
    cyc();
    chk("midrst_P1_C", 32'(st_a[3:2]), 32'd2);
    chk("midrst_x_held", 32'(x_a), 32'd0);
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("midrst_state", 32'(st_a), 32'd0);
    chk("midrst_x", 32'(x_a), 32'd1);
    chk("midrst_gv", 32'(gv_a), 32'd0);
    tr = 5'b01111; cyc(); tr = '0;
    cyc();
    chk("midrst_ptr0_gv", 32'(gv_a), 32'd1);
    chk("midrst_ptr0_gidx", 32'(gi_a), 32'd0);
    cyc(); cyc();
    chk("midrst_tmr_C", 32'(st_a[1:0]), 32'd2);
    cyc();
    chk("midrst_tmr_E", 32'(st_a[1:0]), 32'd3);

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      tr = 5'($urandom);
      er = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
      reset = ($urandom_range(0, 299) == 0);
      cyc();
    end
    reset = 1'b0; tr = '0; er = '0;
    cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
